// File: rtl/friscv_apb_arbiter.sv
// Round-robin arbiter serializing NREQ requesters onto one APB-style slave.
// One slave access per grant, with a watchdog that aborts silent accesses.
module friscv_apb_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic [NREQ-1:0]         req_en,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0]    req_wdata,
  input  logic [NREQ*XLEN/8-1:0]  req_strb,
  output logic [XLEN-1:0]         req_rdata,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_err,
  output logic                    mst_en,
  output logic                    mst_wr,
  output logic [ADDRW-1:0]        mst_addr,
  output logic [XLEN-1:0]         mst_wdata,
  output logic [XLEN/8-1:0]       mst_strb,
  input  logic [XLEN-1:0]         mst_rdata,
  input  logic                    mst_ready,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mst_en_q, mst_en_d;
  logic              mst_wr_q, mst_wr_d;
  logic [ADDRW-1:0]  mst_addr_q, mst_addr_d;
  logic [XLEN-1:0]   mst_wdata_q, mst_wdata_d;
  logic [SW-1:0]     mst_strb_q, mst_strb_d;
  logic [XLEN-1:0]   req_rdata_q, req_rdata_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   req_err_q, req_err_d;
  logic              busy_q, busy_d;

  logic              gnt_ok;
  logic [PW-1:0]     gnt_idx;

  // Scan downward so the last hit is the first requester at or after ptr.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      logic [PW:0] c;
      c = {1'b0, ptr_q} + (PW+1)'(i);
      if (c >= (PW+1)'(NREQ))
        c = c - (PW+1)'(NREQ);
      if (req_en[c[PW-1:0]]) begin
        gnt_ok  = 1'b1;
        gnt_idx = c[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mst_en_d    = mst_en_q;
    mst_wr_d    = mst_wr_q;
    mst_addr_d  = mst_addr_q;
    mst_wdata_d = mst_wdata_q;
    mst_strb_d  = mst_strb_q;
    req_rdata_d = req_rdata_q;
    req_ready_d = req_ready_q;
    req_err_d   = req_err_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_ok) begin
          grant_d     = gnt_idx;
          ptr_d       = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          mst_en_d    = 1'b1;
          mst_wr_d    = req_wr[gnt_idx];
          mst_addr_d  = req_addr[gnt_idx*ADDRW +: ADDRW];
          mst_wdata_d = req_wdata[gnt_idx*XLEN +: XLEN];
          mst_strb_d  = req_strb[gnt_idx*SW +: SW];
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mst_ready) begin
          mst_en_d             = 1'b0;
          req_rdata_d          = mst_wr_q ? '0 : mst_rdata;
          req_ready_d          = '0;
          req_ready_d[grant_q] = 1'b1;
          req_err_d            = '0;
          state_d              = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          mst_en_d             = 1'b0;
          req_rdata_d          = '0;
          req_ready_d          = '0;
          req_ready_d[grant_q] = 1'b1;
          req_err_d            = '0;
          req_err_d[grant_q]   = 1'b1;
          state_d              = DONE;
        end
      end
      DONE: begin
        req_ready_d = '0;
        req_err_d   = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    if (srst) begin
      state_d     = IDLE;
      ptr_d       = '0;
      grant_d     = '0;
      cnt_d       = '0;
      mst_en_d    = 1'b0;
      mst_wr_d    = 1'b0;
      mst_addr_d  = '0;
      mst_wdata_d = '0;
      mst_strb_d  = '0;
      req_rdata_d = '0;
      req_ready_d = '0;
      req_err_d   = '0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      mst_en_q    <= 1'b0;
      mst_wr_q    <= 1'b0;
      mst_addr_q  <= '0;
      mst_wdata_q <= '0;
      mst_strb_q  <= '0;
      req_rdata_q <= '0;
      req_ready_q <= '0;
      req_err_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mst_en_q    <= mst_en_d;
      mst_wr_q    <= mst_wr_d;
      mst_addr_q  <= mst_addr_d;
      mst_wdata_q <= mst_wdata_d;
      mst_strb_q  <= mst_strb_d;
      req_rdata_q <= req_rdata_d;
      req_ready_q <= req_ready_d;
      req_err_q   <= req_err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_rdata = req_rdata_q;
  assign req_ready = req_ready_q;
  assign req_err   = req_err_q;
  assign mst_en    = mst_en_q;
  assign mst_wr    = mst_wr_q;
  assign mst_addr  = mst_addr_q;
  assign mst_wdata = mst_wdata_q;
  assign mst_strb  = mst_strb_q;
  assign busy      = busy_q;

endmodule
